// File: rtl/proj_mailbox_pkg.sv
// proj_mailbox_pkg
//   Shared constants and helpers for the per-project Wishbone write mailbox.
//   MAILBOX_DEPTH_DEFAULT / MAILBOX_WIDTH_DEFAULT : default FIFO geometry
//   DROP_CNT_W                                    : width of the dropped-write counter
//   pack_status()                                 : status word for harness readback,
//                                                   {overflow, 7'b0, drop_cnt, 8'b0, level}
package proj_mailbox_pkg;

   localparam int unsigned MAILBOX_DEPTH_DEFAULT = 8;
   localparam int unsigned MAILBOX_WIDTH_DEFAULT = 32;
   localparam int unsigned DROP_CNT_W            = 8;

   function automatic logic [31:0] pack_status(input logic                  overflow,
                                                input logic [DROP_CNT_W-1:0] drop_cnt,
                                                input logic [7:0]            level);
      return {overflow, 7'b0, drop_cnt, 8'b0, level};
   endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo
//   Synchronous FIFO: storage array, wrap-bit pointers, full/empty and level.
//   Ports:
//     clk_i    : clock (rising edge)
//     clr_i    : synchronous clear of both pointers (storage not cleared)
//     push_i   : write request; accepted when not full or when popping
//     pop_i    : read request; caller only asserts it while not empty
//     wdata_i  : write data
//     rdata_o  : head word (combinational read of registered storage)
//     empty_o  : no stored words
//     full_o   : DEPTH stored words
//     level_o  : number of stored words
module mailbox_fifo
   import proj_mailbox_pkg::*;
#(
   parameter int unsigned DEPTH = MAILBOX_DEPTH_DEFAULT,
   parameter int unsigned WIDTH = MAILBOX_WIDTH_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             wr_en;
   logic             rd_en;

   // Same-cycle pop frees the slot the push needs, so a full FIFO still accepts.
   assign wr_en = push_i & (~full_o | pop_i);
   assign rd_en = pop_i & ~empty_o;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
   end

   // Storage has no reset; a clear only moves the pointers.
   always_ff @(posedge clk_i) begin
      if (wr_en && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/proj_wb_mailbox.sv
// proj_wb_mailbox
//   Per-project write mailbox: captures wb_dat_i once per rising edge of the
//   harness write-update strobe, queues it, and streams it out over valid/ready.
//   Optional feature macro: PROJ_WB_MAILBOX_DROPCNT_EN (saturating drop counter;
//   when undefined drop_cnt_o is tied to zero).
//   Ports:
//     wb_clk_i   : clock (rising edge)
//     wb_rst_i   : synchronous active-high reset
//     wb_update_i: write-update strobe (may stay high several cycles per write)
//     wb_dat_i   : Wishbone write data
//     flush_i    : synchronous clear from project reset
//     m_valid_o  : head word available
//     m_data_o   : head word
//     m_ready_i  : consumer accepts head word
//     level_o    : stored word count
//     full_o     : level_o == DEPTH
//     overflow_o : sticky, a write was dropped
//     drop_cnt_o : saturating dropped-write count
module proj_wb_mailbox
   import proj_mailbox_pkg::*;
#(
   parameter int unsigned DEPTH = MAILBOX_DEPTH_DEFAULT,
   parameter int unsigned WIDTH = MAILBOX_WIDTH_DEFAULT
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wb_update_i,
   input  logic [WIDTH-1:0]        wb_dat_i,
   input  logic                    flush_i,
   output logic                    m_valid_o,
   output logic [WIDTH-1:0]        m_data_o,
   input  logic                    m_ready_i,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    full_o,
   output logic                    overflow_o,
   output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

   logic upd_q, upd_d;
   logic overflow_q, overflow_d;
   logic clr;
   logic push;
   logic pop;
   logic drop;
   logic empty;

   assign clr  = wb_rst_i | flush_i;
   assign push = wb_update_i & ~upd_q;
   assign pop  = m_valid_o & m_ready_i;
   // Clear outranks a push, so a push during clear is lost without counting.
   assign drop = push & full_o & ~pop & ~clr;

   assign m_valid_o  = ~empty;
   assign overflow_o = overflow_q;

   always_comb begin
      upd_d = wb_update_i;
      overflow_d = overflow_q;
      if (clr)       overflow_d = 1'b0;
      else if (drop) overflow_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         upd_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         upd_q      <= upd_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef PROJ_WB_MAILBOX_DROPCNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clr)                             drop_cnt_d = '0;
      else if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) drop_cnt_q <= '0;
      else          drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = '0;
`endif

   mailbox_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .clr_i   (clr),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wb_dat_i),
      .rdata_o (m_data_o),
      .empty_o (empty),
      .full_o  (full_o),
      .level_o (level_o)
   );

endmodule

// File: tb/tb_proj_wb_mailbox.sv
// tb_proj_wb_mailbox
//   Directed bench for proj_wb_mailbox with a queue-based reference model and
//   a per-cycle compare process, plus literal expectations on key scenarios.
module tb_proj_wb_mailbox;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             upd = 1'b0;
   logic [WIDTH-1:0] dat = '0;
   logic             flush = 1'b0;
   logic             rdy = 1'b0;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic [LW-1:0]    level;
   logic             full;
   logic             overflow;
   logic [7:0]       drop_cnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   proj_wb_mailbox #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb_update_i (upd),
      .wb_dat_i    (dat),
      .flush_i     (flush),
      .m_valid_o   (m_valid),
      .m_data_o    (m_data),
      .m_ready_i   (rdy),
      .level_o     (level),
      .full_o      (full),
      .overflow_o  (overflow),
      .drop_cnt_o  (drop_cnt)
   );

   // Reference model: a queue of accepted words plus sticky/drop bookkeeping.
   logic [WIDTH-1:0] mq[$];
   bit               m_prev = 1'b0;
   bit               m_ovf  = 1'b0;
   int               m_drops = 0;
   bit               m_push, m_pop;

   always @(posedge clk) begin
      m_push = upd && !m_prev;
      m_pop  = (mq.size() != 0) && rdy;
      if (rst || flush) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (mq.size() < DEPTH) mq.push_back(dat);
            else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
      m_prev = rst ? 1'b0 : upd;
   end

   function automatic int exp_drops();
`ifdef PROJ_WB_MAILBOX_DROPCNT_EN
      return m_drops;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", 32'(m_valid), 32'(mq.size() != 0));
         check("model_level", 32'(level), 32'(mq.size()));
         check("model_full", 32'(full), 32'(mq.size() == DEPTH));
         check("model_overflow", 32'(overflow), 32'(m_ovf));
         check("model_drop_cnt", 32'(drop_cnt), 32'(exp_drops()));
         if (mq.size() != 0) check("model_data", m_data, mq[0]);
      end
   end

   // Inputs change 1 time unit after a rising edge; literal checks right after
   // a step observe the state registered on that edge.
   task automatic step(input logic u, input logic [WIDTH-1:0] d, input logic r,
                       input logic f, input logic rs);
      upd = u; dat = d; rdy = r; flush = f; rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [WIDTH-1:0] d, input logic r);
      step(1'b1, d, r, 1'b0, 1'b0);
      step(1'b0, d, r, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_full", 32'(full), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Single write, strobe held two cycles
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      check("single_level_n1", 32'(level), 32'd1);
      check("single_data", m_data, 32'hDEADBEEF);
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      check("single_level_held", 32'(level), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("single_valid", 32'(m_valid), 32'd1);

      // Order
      do_reset();
      write_word(32'd1, 1'b0);
      write_word(32'd2, 1'b0);
      write_word(32'd3, 1'b0);
      check("order_head1", m_data, 32'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("order_head2", m_data, 32'd2);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("order_head3", m_data, 32'd3);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("order_empty_valid", 32'(m_valid), 32'd0);
      check("order_empty_level", 32'(level), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Overflow: 10 writes into 8 entries
      do_reset();
      for (int i = 0; i < 10; i++) write_word(32'h100 + 32'(i), 1'b0);
      check("ovf_level", 32'(level), 32'd8);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
`ifdef PROJ_WB_MAILBOX_DROPCNT_EN
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`else
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      for (int i = 0; i < 8; i++) begin
         check("ovf_readback", m_data, 32'h100 + 32'(i));
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      check("ovf_drained", 32'(m_valid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 8; i++) write_word(32'(i), 1'b0);
      step(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
      check("fpp_level", 32'(level), 32'd8);
      check("fpp_overflow", 32'(overflow), 32'd0);
      check("fpp_head", m_data, 32'd2);
      for (int i = 2; i <= 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("fpp_last", m_data, 32'hAA);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("fpp_empty", 32'(m_valid), 32'd0);

      // Flush priority over a same-cycle push
      do_reset();
      for (int i = 0; i < 3; i++) write_word(32'h200 + 32'(i), 1'b0);
      step(1'b1, 32'hBAD, 1'b0, 1'b1, 1'b0);
      check("flush_level", 32'(level), 32'd0);
      check("flush_valid", 32'(m_valid), 32'd0);
      check("flush_overflow", 32'(overflow), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      write_word(32'h55, 1'b0);
      check("flush_after_data", m_data, 32'h55);
      check("flush_after_level", 32'(level), 32'd1);

      // Reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) write_word(32'h300 + 32'(i), 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("rst_mid_valid", 32'(m_valid), 32'd0);
      check("rst_mid_level", 32'(level), 32'd0);
      check("rst_mid_full", 32'(full), 32'd0);
      check("rst_mid_overflow", 32'(overflow), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("rst_mid_no_stale", 32'(m_valid), 32'd0);

      // Strobe already high in the first cycle after reset counts as an edge
      step(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      check("post_rst_edge_level", 32'(level), 32'd1);
      check("post_rst_edge_data", m_data, 32'h77);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Drop counter saturation
      do_reset();
      for (int i = 0; i < 8; i++) write_word(32'(i), 1'b0);
      for (int i = 0; i < 260; i++) write_word(32'hF00, 1'b0);
`ifdef PROJ_WB_MAILBOX_DROPCNT_EN
      check("drop_saturate", 32'(drop_cnt), 32'd255);
`else
      check("drop_saturate", 32'(drop_cnt), 32'd0);
`endif
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("drop_flush_clear", 32'(drop_cnt), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
